// File: rtl/po2_quantize_if.sv
`default_nettype none
// ============================================================================
// po2_quantize_if : weight-in / power-of-two-result handshake bundle
// Revision 1.0
// ============================================================================
interface po2_quantize_if #(
  parameter int W = 16
);
  logic [W-1:0] in_weight;
  logic         in_v;
  logic         in_ready;
  logic         zero_weight;
  logic         negative_weight;
  logic [W-1:0] log_2_weight;
  logic         saturated;
  logic         out_v;
  logic         out_ready;

  modport master (
    output in_weight, in_v, out_ready,
    input  in_ready, zero_weight, negative_weight, log_2_weight, saturated, out_v
  );

  modport slave (
    input  in_weight, in_v, out_ready,
    output in_ready, zero_weight, negative_weight, log_2_weight, saturated, out_v
  );
endinterface
`default_nettype wire

// File: rtl/po2_quantize.sv
`default_nettype none
// ============================================================================
// po2_quantize : rounds a signed fixed-point weight to +/-2^-k (or zero)
// Revision 1.0
// ============================================================================
module po2_quantize #(
  parameter int W = 16,
  parameter int I = 4
) (
  input  wire             clk,
  input  wire             rst_n,
  po2_quantize_if.slave   bus
);
  localparam int             c_frac = W - I;
  localparam int             c_jw   = (W > 1) ? $clog2(W) : 1;
  localparam logic [W-1:0]   c_one  = W'(1) << c_frac;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ABS   = 3'd1,
    S_SCAN  = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      w_q, w_d;
  logic [W-1:0]      m_q, m_d;
  logic [W-1:0]      k_q, k_d;
  logic [c_jw-1:0]   j_q, j_d;
  logic              sign_q, sign_d;
  logic [W-1:0]      log2_q, log2_d;
  logic              zero_q, zero_d;
  logic              neg_q, neg_d;
  logic              sat_q, sat_d;
  logic              in_ready_q, in_ready_d;
  logic              out_v_q, out_v_d;

  logic [W-1:0]      w_abs;
  logic [c_jw-1:0]   j_m1;

  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    m_d        = m_q;
    k_d        = k_q;
    j_d        = j_q;
    sign_d     = sign_q;
    log2_d     = log2_q;
    zero_d     = zero_q;
    neg_d      = neg_q;
    sat_d      = sat_q;
    in_ready_d = in_ready_q;
    out_v_d    = out_v_q;
    // Two's complement of the most-negative value wraps to itself, which
    // still compares >= 1.0 and therefore saturates as intended.
    w_abs      = w_q[W-1] ? (~w_q + W'(1)) : w_q;
    j_m1       = j_q - c_jw'(1);

    case (state_q)
      S_IDLE: begin
        if (bus.in_v) begin
          w_d        = bus.in_weight;
          in_ready_d = 1'b0;
          state_d    = S_ABS;
        end
      end
      S_ABS: begin
        sign_d = w_q[W-1];
        m_d    = w_abs;
        if (w_q == '0) begin
          zero_d  = 1'b1;
          neg_d   = 1'b0;
          log2_d  = '0;
          sat_d   = 1'b0;
          out_v_d = 1'b1;
          state_d = S_DONE;
        end else if (w_abs >= c_one) begin
          zero_d  = 1'b0;
          neg_d   = w_q[W-1];
          log2_d  = '0;
          sat_d   = 1'b1;
          out_v_d = 1'b1;
          state_d = S_DONE;
        end else begin
          k_d     = W'(1);
          j_d     = c_jw'(c_frac - 1);
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (m_q[j_q]) begin
          state_d = S_ROUND;
        end else begin
          k_d = k_q + W'(1);
          j_d = j_m1;
        end
      end
      S_ROUND: begin
        // The bit below the leading one decides the half-way point; ties go up.
        log2_d  = ((j_q != '0) && m_q[j_m1]) ? (k_q - W'(1)) : k_q;
        neg_d   = sign_q;
        zero_d  = 1'b0;
        sat_d   = 1'b0;
        out_v_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_v_d    = 1'b0;
          in_ready_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: begin
        out_v_d    = 1'b0;
        in_ready_d = 1'b1;
        state_d    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      w_q        <= '0;
      m_q        <= '0;
      k_q        <= '0;
      j_q        <= '0;
      sign_q     <= 1'b0;
      log2_q     <= '0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      sat_q      <= 1'b0;
      in_ready_q <= 1'b1;
      out_v_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      m_q        <= m_d;
      k_q        <= k_d;
      j_q        <= j_d;
      sign_q     <= sign_d;
      log2_q     <= log2_d;
      zero_q     <= zero_d;
      neg_q      <= neg_d;
      sat_q      <= sat_d;
      in_ready_q <= in_ready_d;
      out_v_q    <= out_v_d;
    end
  end

  assign bus.in_ready        = in_ready_q;
  assign bus.out_v           = out_v_q;
  assign bus.zero_weight     = zero_q;
  assign bus.negative_weight = neg_q;
  assign bus.saturated       = sat_q;
  assign bus.log_2_weight    = log2_q;
endmodule
`default_nettype wire

// File: tb/tb_po2_quantize.sv
`default_nettype none
// ============================================================================
// tb_po2_quantize : directed and randomized checks of po2_quantize
// Revision 1.0
// ============================================================================
module tb_po2_quantize;
  localparam int W = 16;
  localparam int I = 4;
  localparam int F = W - I;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [18:0] prev_res = '0;
  logic [18:0] obs_res;

  po2_quantize_if #(.W(W)) bus ();

  po2_quantize #(.W(W), .I(I)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign obs_res = {bus.zero_weight, bus.negative_weight, bus.saturated, bus.log_2_weight};

  function automatic logic [18:0] fields(input logic z, input logic n, input logic s, input int k);
    return {z, n, s, 16'(k)};
  endfunction

  // Reference: value-domain rounding to the nearest power of two.
  function automatic void model(input logic [15:0] w, output logic [18:0] res, output int lat);
    int v, m, j, k;
    v = int'($signed(w));
    m = (v < 0) ? -v : v;
    if (v == 0) begin
      res = fields(1'b1, 1'b0, 1'b0, 0);
      lat = 1;
    end else if (m >= (1 << F)) begin
      res = fields(1'b0, v < 0, 1'b1, 0);
      lat = 1;
    end else begin
      j = 0;
      while ((1 << (j + 1)) <= m) j++;
      k   = F - j;
      lat = 2 + k;
      if (2 * m >= 3 * (1 << j)) k--;
      res = fields(1'b0, v < 0, 1'b0, k);
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_one(input logic [15:0] w, input logic [18:0] exp_res, input int exp_lat,
                        input string tag);
    int lat;
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_weight = w;
    bus.in_v      = 1'b1;
    @(posedge clk); #1;
    bus.in_v      = 1'b0;
    bus.in_weight = 16'hFFFF;
    lat = 0;
    while (!bus.out_v && lat < 40) begin
      check({tag, "_hold_prev"}, 32'(obs_res), 32'(prev_res));
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, 32'(obs_res), 32'(exp_res));
    check({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
    prev_res = exp_res;
  endtask

  task automatic consume(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_out_v_drop"}, 32'(bus.out_v), 32'd0);
    check({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] q_w[$];
    logic [18:0] exp_res;
    logic [15:0] w;
    int          exp_lat;
    int          n_acc;
    int          guard;
    logic        acc, cons;

    bus.in_weight = '0;
    bus.in_v      = 1'b0;
    bus.out_ready = 1'b0;

    #12;
    check("rst_out_v", 32'(bus.out_v), 32'd0);
    check("rst_fields", 32'(obs_res), 32'd0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    do_one(16'h0800, fields(0, 0, 0, 1), 3, "half");
    consume("half");
    do_one(16'h0C00, fields(0, 0, 0, 0), 3, "three_q");
    consume("three_q");
    do_one(16'hFE00, fields(0, 1, 0, 3), 5, "neg_eighth");
    consume("neg_eighth");
    do_one(16'h0000, fields(1, 0, 0, 0), 1, "zero");
    consume("zero");
    do_one(16'h2000, fields(0, 0, 1, 0), 1, "sat_pos");
    consume("sat_pos");
    do_one(16'h8000, fields(0, 1, 1, 0), 1, "sat_min");
    consume("sat_min");

    do_one(16'h0001, fields(0, 0, 0, 12), 14, "lsb");
    bus.in_weight = 16'h0800;
    bus.in_v      = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("stall_out_v", 32'(bus.out_v), 32'd1);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check("stall_fields", 32'(obs_res), 32'(prev_res));
    end
    consume("lsb");
    bus.in_v = 1'b0;
    @(posedge clk); #1;
    check("no_accept_on_consume", 32'(bus.in_ready), 32'd1);

    bus.in_weight = 16'h0001;
    bus.in_v      = 1'b1;
    @(posedge clk); #1;
    bus.in_v = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midscan_rst_out_v", 32'(bus.out_v), 32'd0);
    check("midscan_rst_log", 32'(bus.log_2_weight), 32'd0);
    check("midscan_rst_fields", 32'(obs_res), 32'd0);
    #2 rst_n = 1'b1;
    prev_res = '0;
    @(posedge clk); #1;
    check("midscan_rst_in_ready", 32'(bus.in_ready), 32'd1);
    do_one(16'h0400, fields(0, 0, 0, 2), 4, "after_rst");
    consume("after_rst");

    n_acc = 0;
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 3))
        0:       w = 16'($urandom);
        1:       w = 16'h1000 >> $urandom_range(0, 12);
        2:       w = 16'($urandom) >> $urandom_range(3, 15);
        default: w = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h0000;
      endcase
      if ($urandom_range(0, 1) != 0) w = -w;
      bus.in_weight = w;
      bus.in_v      = ($urandom_range(0, 2) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      acc  = bus.in_v && bus.in_ready;
      cons = bus.out_v && bus.out_ready;
      if (bus.in_ready && bus.out_v) check("rnd_ready_and_valid", 32'd1, 32'd0);
      if (cons) begin
        if (q_w.size() == 0) begin
          check("rnd_spurious_result", 32'd1, 32'd0);
        end else begin
          model(q_w.pop_front(), exp_res, exp_lat);
          check("rnd_result", 32'(obs_res), 32'(exp_res));
        end
      end
      if (acc) begin
        q_w.push_back(w);
        n_acc++;
      end
      @(posedge clk); #1;
    end

    bus.in_v      = 1'b0;
    bus.out_ready = 1'b1;
    guard = 0;
    while (q_w.size() != 0 && guard < 100) begin
      if (bus.out_v) begin
        model(q_w.pop_front(), exp_res, exp_lat);
        check("drain_result", 32'(obs_res), 32'(exp_res));
      end
      @(posedge clk); #1;
      guard++;
    end
    check("drain_empty", 32'(q_w.size()), 32'd0);
    check("rnd_accepted_some", 32'(n_acc > 100), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/po2_quantize.md
PO2_QUANTIZE -- requirements
Module: po2_quantize

Interface
REQ-001 SHALL have parameter W, default 16, element width in bits.
REQ-002 SHALL have parameter I, default 4, integer bits in W (fraction F = W-I; 1.0 = 1<<F).
REQ-003 SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port in_weight, input, W, signed fixed-point weight to quantize.
REQ-006 SHALL have port in_v, input, 1, in_weight valid.
REQ-007 SHALL have port in_ready, output, 1, block can accept a weight.
REQ-008 SHALL have port zero_weight, output, 1, quantized weight is zero.
REQ-009 SHALL have port negative_weight, output, 1, quantized weight is negative.
REQ-010 SHALL have port log_2_weight, output, W, unsigned k where |quantized weight| = 2^-k.
REQ-011 SHALL have port saturated, output, 1, |in_weight| >= 1.0, clamped to k=0.
REQ-012 SHALL have port out_v, output, 1, result fields valid.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts result.

Function
REQ-014 SHALL implement states IDLE, ABS, SCAN, ROUND, DONE; in_ready = 1 only in IDLE; out_v = 1 only in DONE.
REQ-015 SHALL, in IDLE with in_v=1, capture in_weight at that edge and move to ABS; in_weight is ignored afterwards until next IDLE.
REQ-016 SHALL, in ABS, form sign = in_weight[W-1] and W-bit unsigned magnitude m = |in_weight|; most-negative input (only MSB set) treated as m >= 1.0.
REQ-017 SHALL, in ABS with in_weight == 0: zero_weight=1, negative_weight=0, log_2_weight=0, saturated=0, go to DONE.
REQ-018 SHALL, in ABS with m >= 1<<F: zero_weight=0, negative_weight=sign, log_2_weight=0, saturated=1, go to DONE.
REQ-019 SHALL otherwise enter SCAN with k=1, bit index j=F-1.
REQ-020 SHALL, in SCAN, test one bit per cycle: m[j]=1 -> ROUND; else k<=k+1, j<=j-1; j never underflows since 0 < m < 1.0 (k max = F).
REQ-021 SHALL, in ROUND, round to nearest power of two: if j>0 and m[j-1]=1 then k<=k-1 (ties round up in magnitude); then DONE with negative_weight=sign, zero_weight=0, saturated=0.
REQ-022 SHALL reach out_v=1 at edge 1 after accept for zero/saturated inputs, else at edge 2+kscan after accept (kscan = k before rounding); latency range 1..F+2 cycles.
REQ-023 SHALL hold all result outputs stable in DONE while out_ready=0; in DONE with out_ready=1, return to IDLE at that edge, out_v low next cycle.
REQ-024 SHALL not accept a new weight on the same edge a result is consumed (in_ready=0 in DONE); max one weight in flight.
REQ-025 SHALL keep result outputs unchanged from last DONE while in IDLE/ABS/SCAN/ROUND; only out_v qualifies them.
REQ-026 SHALL produce encodings directly consumable by the power-of-two multiplier: product = input >>> log_2_weight, negated when negative_weight.

Reset
REQ-027 SHALL, on rst_n low at any time including mid-SCAN or in DONE, immediately enter IDLE, clear out_v, zero_weight, negative_weight, saturated, log_2_weight to 0; in-flight weight is discarded.
REQ-028 SHALL present in_ready=1 from the first cycle after rst_n deasserts.

Verification (W=16, I=4)
REQ-029 SHALL cover in_weight=0x0800 (0.5) -> out_v after 3 edges, log_2_weight=1, negative_weight=0, zero_weight=0.
REQ-030 SHALL cover in_weight=0x0C00 (0.75) -> rounds up, log_2_weight=0, saturated=0; in_weight=0xFE00 (-0.125) -> log_2_weight=3, negative_weight=1.
REQ-031 SHALL cover in_weight=0x0000 -> zero_weight=1 after 1 edge; in_weight=0x2000 and 0x8000 -> saturated=1, log_2_weight=0, negative_weight 0 and 1 respectively.
REQ-032 SHALL cover in_weight=0x0001 -> log_2_weight=12, out_v after 14 edges; hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0 throughout.
REQ-033 SHALL cover rst_n pulsed low during SCAN of 0x0001 -> out_v=0, log_2_weight=0 immediately, in_ready=1 after deassert, next weight 0x0400 -> log_2_weight=2.
REQ-034 SHALL cover back-to-back stream with random in_v/out_ready against a reference model; each accepted weight yields exactly one result, in order.
